player_ctrl: RTL and testbench

Per-frame position controller for one pong paddle. Watches the VS bit of the RGB stream entering the player drawing stage, samples the paddle buttons once per frame and drives the 10-bit `pos` consumed by the player drawing block. Handles hold-to-accelerate speed ramping and clamps the paddle to the screen edge. Position changes only during vertical sync, so a frame never shows a torn paddle.

---
 rtl/player_ctrl_if.sv | 21 ++
 rtl/player_ctrl.sv | 157 +++++++++++++++
 tb/tb_player_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/player_ctrl_if.sv
// Signal bundle between the RGB/button front end and the paddle position controller.
// The master drives stream, buttons and AI inputs; the slave (player_ctrl) returns pos and moving.
interface player_ctrl_if;
  logic [25:0] strRGB_i;
  logic        btn_up;
  logic        btn_down;
  logic        ai_mode;
  logic [9:0]  ball_pos;
  logic [9:0]  pos;
  logic        moving;

  modport master (
    output strRGB_i, btn_up, btn_down, ai_mode, ball_pos,
    input  pos, moving
  );

  modport slave (
    input  strRGB_i, btn_up, btn_down, ai_mode, ball_pos,
    output pos, moving
  );
endinterface

// File: rtl/player_ctrl.sv
// Per-frame pong paddle position controller: button/AI direction, hold-to-accelerate, edge clamp.
// Define PLAYER_AI_EN to enable automatic ball tracking when ai_mode is high.
module player_ctrl #(
  parameter bit paddle_type  = 1'b0,  // 0: vertical (extent 600), 1: horizontal (extent 800)
  parameter int size_player  = 80,
  parameter int pos_init     = 260,
  parameter int speed_min    = 1,
  parameter int speed_max    = 8,
  parameter int accel_frames = 4
) (
  input  logic         px_clk,
  input  logic         reset,
  player_ctrl_if.slave bus
);

  localparam int          extent  = paddle_type ? 800 : 600;
  localparam int          limit   = extent - size_player;
  localparam logic [10:0] limit_c = 11'(limit);

  typedef enum logic [1:0] {ST_WAIT, ST_SAMPLE, ST_STEP, ST_CLAMP} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t      state_reg, state_next;
  dir_t        dir_reg, dir_next, dir_sample;
  logic [9:0]  speed_reg, speed_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [10:0] cand_reg, cand_next;
  logic [9:0]  pos_reg, pos_next, pos_clamped;
  logic        moving_reg, moving_next;
  logic        vs_d_reg;
  logic        tick;

  // Two-flop synchronizers: bit 0 = up, bit 1 = down
  logic [1:0] btn_raw, btn_sync;
  assign btn_raw = {bus.btn_down, bus.btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg, s2_reg;
      always_ff @(posedge px_clk) begin
        if (reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= btn_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign btn_sync[gi] = s2_reg;
    end
  endgenerate

  assign tick = bus.strRGB_i[1] & ~vs_d_reg;

`ifdef PLAYER_AI_EN
  logic [10:0] centre, ball_ext;
  assign centre   = {1'b0, pos_reg} + 11'(size_player / 2);
  assign ball_ext = {1'b0, bus.ball_pos};
  logic unused_rgb;
  assign unused_rgb = ^{bus.strRGB_i[25:2], bus.strRGB_i[0]};
`else
  logic unused_ai;
  assign unused_ai = ^{bus.ai_mode, bus.ball_pos, bus.strRGB_i[25:2], bus.strRGB_i[0]};
`endif

  always_comb begin
    dir_sample = DIR_NONE;
`ifdef PLAYER_AI_EN
    if (bus.ai_mode) begin
      if (ball_ext + 11'd4 < centre)      dir_sample = DIR_UP;
      else if (ball_ext > centre + 11'd4) dir_sample = DIR_DOWN;
    end else
`endif
    begin
      if (btn_sync[0] && !btn_sync[1])      dir_sample = DIR_UP;
      else if (btn_sync[1] && !btn_sync[0]) dir_sample = DIR_DOWN;
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_reg  <= ST_WAIT;
      dir_reg    <= DIR_NONE;
      speed_reg  <= 10'(speed_min);
      cnt_reg    <= 8'd0;
      cand_reg   <= 11'd0;
      pos_reg    <= 10'(pos_init);
      moving_reg <= 1'b0;
      vs_d_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      dir_reg    <= dir_next;
      speed_reg  <= speed_next;
      cnt_reg    <= cnt_next;
      cand_reg   <= cand_next;
      pos_reg    <= pos_next;
      moving_reg <= moving_next;
      vs_d_reg   <= bus.strRGB_i[1];
    end
  end

  always_comb begin
    state_next  = state_reg;
    dir_next    = dir_reg;
    speed_next  = speed_reg;
    cnt_next    = cnt_reg;
    cand_next   = cand_reg;
    pos_next    = pos_reg;
    moving_next = moving_reg;
    pos_clamped = cand_reg[9:0];

    case (state_reg)
      ST_WAIT: begin
        if (tick) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_next = ST_STEP;
        dir_next   = dir_sample;
        if (dir_sample == dir_reg && dir_sample != DIR_NONE) begin
          if (cnt_reg + 8'd1 == 8'(accel_frames)) begin
            cnt_next = 8'd0;
            if (speed_reg < 10'(speed_max)) speed_next = speed_reg + 10'd1;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end else if (dir_sample != dir_reg) begin
          speed_next = 10'(speed_min);
          cnt_next   = 8'd0;
        end
      end
      ST_STEP: begin
        state_next = ST_CLAMP;
        case (dir_reg)
          DIR_UP:   cand_next = {1'b0, pos_reg} - {1'b0, speed_reg};
          DIR_DOWN: cand_next = {1'b0, pos_reg} + {1'b0, speed_reg};
          default:  cand_next = {1'b0, pos_reg};
        endcase
      end
      ST_CLAMP: begin
        state_next = ST_WAIT;
        // Underflow is caught from the operands, not the wrapped difference
        if (dir_reg == DIR_UP && pos_reg < speed_reg)
          pos_clamped = 10'd0;
        else if (dir_reg == DIR_DOWN && cand_reg > limit_c)
          pos_clamped = limit_c[9:0];
        pos_next    = pos_clamped;
        moving_next = (pos_clamped != pos_reg);
      end
      default: state_next = ST_WAIT;
    endcase
  end

  assign bus.pos    = pos_reg;
  assign bus.moving = moving_reg;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: ramp, clamps, restart, tick timing, reset behaviour, AI mode.
module tb_player_ctrl;
  logic px_clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 px_clk = ~px_clk;

  player_ctrl_if bus ();

  player_ctrl #(
    .paddle_type(1'b0), .size_player(80), .pos_init(260),
    .speed_min(1), .speed_max(8), .accel_frames(4)
  ) dut (
    .px_clk(px_clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_pm(input string tag, input int p, input logic m);
    chk({tag, "_pos"}, 16'(bus.pos), 16'(p));
    chk({tag, "_moving"}, 16'(bus.moving), 16'(m));
    $display("%s: pos=%0d moving=%0d", tag, bus.pos, bus.moving);
  endtask

  task automatic set_vs(input logic v);
    bus.strRGB_i = {24'h5A5A5A, v, 1'b1};
  endtask

  task automatic btns(input logic u, input logic d);
    bus.btn_up   = u;
    bus.btn_down = d;
    repeat (4) @(negedge px_clk);
  endtask

  task automatic frame();
    set_vs(1'b1);
    repeat (8) @(negedge px_clk);
    set_vs(1'b0);
    repeat (8) @(negedge px_clk);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic do_reset();
    @(negedge px_clk);
    reset = 1'b1;
    repeat (3) @(negedge px_clk);
    reset = 1'b0;
    @(negedge px_clk);
  endtask

  int exp_down[9] = '{262, 263, 264, 266, 268, 270, 272, 275, 278};

  initial begin
    reset        = 1'b1;
    set_vs(1'b1);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b1;
    bus.ai_mode  = 1'b0;
    bus.ball_pos = 10'd0;
    repeat (4) @(negedge px_clk);
    chk_pm("reset", 260, 1'b0);

    // VS already high at release with down held: no tick may fire
    reset = 1'b0;
    repeat (8) @(negedge px_clk);
    chk_pm("no_tick_at_release", 260, 1'b0);
    set_vs(1'b0);
    btns(1'b0, 1'b0);
    repeat (8) @(negedge px_clk);

    for (int i = 0; i < 3; i++) begin
      frame();
      chk_pm("idle", 260, 1'b0);
    end

    // First down frame with edge-accurate check: pos holds through E2, updates at E3
    btns(1'b0, 1'b1);
    set_vs(1'b1);
    @(posedge px_clk);
    @(posedge px_clk);
    @(posedge px_clk);
    #1 chk("pre_e3_pos", 16'(bus.pos), 16'd260);
    @(posedge px_clk);
    #1 chk_pm("e3_down1", 261, 1'b1);
    repeat (7) @(negedge px_clk);
    set_vs(1'b0);
    repeat (8) @(negedge px_clk);

    for (int i = 0; i < 9; i++) begin
      frame();
      chk_pm("hold_down", exp_down[i], 1'b1);
    end

    btns(1'b1, 1'b1);
    frame();
    chk_pm("both_pressed", 278, 1'b0);

    // Ramp to speed 5: 1x4 + 2x4 + 3x4 + 4x4 + 5 = 45
    btns(1'b0, 1'b1);
    frames(17);
    chk_pm("ramp_to_5", 323, 1'b1);
    btns(1'b0, 1'b0);
    frame();
    chk_pm("release", 323, 1'b0);
    btns(1'b0, 1'b1);
    frame();
    chk_pm("restart_speed1", 324, 1'b1);
    frame();
    chk_pm("restart_frame2", 325, 1'b1);
    frames(26);
    chk_pm("ramp_to_7", 435, 1'b1);
    frames(10);
    chk_pm("speed8_at_515", 515, 1'b1);
    frame();
    chk_pm("clamp_bottom", 520, 1'b1);
    frame();
    chk_pm("push_bottom", 520, 1'b0);

    btns(1'b1, 1'b0);
    frames(4);
    chk_pm("up_four", 516, 1'b1);
    btns(1'b0, 1'b0);
    frame();
    btns(1'b1, 1'b0);
    frame();
    chk_pm("up_tap", 515, 1'b1);
    btns(1'b0, 1'b0);
    frame();
    btns(1'b1, 1'b0);
    frames(28);
    chk_pm("up_ramp", 403, 1'b1);
    frames(50);
    chk_pm("speed8_at_3", 3, 1'b1);
    frame();
    chk_pm("clamp_top", 0, 1'b1);
    frame();
    chk_pm("push_top", 0, 1'b0);

    // Reset lands in STEP with down held: frame must not update
    btns(1'b0, 1'b1);
    set_vs(1'b1);
    @(posedge px_clk);
    @(posedge px_clk);
    @(negedge px_clk);
    reset = 1'b1;
    @(negedge px_clk);
    @(negedge px_clk);
    reset = 1'b0;
    chk_pm("reset_mid", 260, 1'b0);
    repeat (6) @(negedge px_clk);
    chk_pm("reset_mid_hold", 260, 1'b0);
    set_vs(1'b0);
    repeat (8) @(negedge px_clk);
    frame();
    chk_pm("after_reset_down", 261, 1'b1);

`ifdef PLAYER_AI_EN
    do_reset();
    bus.ai_mode  = 1'b1;
    bus.ball_pos = 10'd302;
    btns(1'b0, 1'b1);
    frame();
    chk_pm("ai_deadband", 260, 1'b0);
    bus.ball_pos = 10'd500;
    btns(1'b1, 1'b0);
    frame();
    chk_pm("ai_track1", 261, 1'b1);
    btns(1'b0, 1'b1);
    frame();
    chk_pm("ai_track2", 262, 1'b1);
    btns(1'b1, 1'b0);
    frame();
    chk_pm("ai_track3", 263, 1'b1);
    btns(1'b1, 1'b1);
    frame();
    chk_pm("ai_track4", 264, 1'b1);
    btns(1'b0, 1'b0);
    frame();
    chk_pm("ai_track5", 266, 1'b1);
`else
    bus.ai_mode  = 1'b1;
    bus.ball_pos = 10'd0;
    frame();
    chk_pm("ai_ignored_down", 262, 1'b1);
    btns(1'b1, 1'b0);
    frame();
    chk_pm("ai_ignored_up", 261, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
